// File: rtl/bram_dual_requester_arbiter.sv
// Shares one dual-port BRAM (port 0 read, port 1 write) between two kernels with independent round-robin arbiters.
// Optional conflict statistics are enabled by defining BRAM_ARB_STATS_EN.
module bram_dual_requester_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              ldreq_valid,
    output logic [1:0]              ldreq_ready,
    input  logic [2*ADDR_WIDTH-1:0] ldreq_addr,
    output logic [1:0]              ldresp_valid,
    input  logic [1:0]              ldresp_ready,
    output logic [2*DATA_WIDTH-1:0] ldresp_data,
    input  logic [1:0]              streq_valid,
    output logic [1:0]              streq_ready,
    input  logic [2*ADDR_WIDTH-1:0] streq_addr,
    input  logic [2*DATA_WIDTH-1:0] streq_data,
    output logic                    ce0,
    output logic                    we0,
    output logic [ADDR_WIDTH-1:0]   address0,
    input  logic [DATA_WIDTH-1:0]   din0,
    output logic                    ce1,
    output logic                    we1,
    output logic [ADDR_WIDTH-1:0]   address1,
    output logic [DATA_WIDTH-1:0]   dout1
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [15:0]             stat_ld_conflicts,
    output logic [15:0]             stat_st_conflicts
`endif
);

    logic                  ld_ptr_reg;
    logic                  st_ptr_reg;
    logic [1:0]            inflight_reg;
    logic [1:0]            resp_valid_reg;
    logic [DATA_WIDTH-1:0] resp_data_reg [2];

    logic [ADDR_WIDTH-1:0] ld_addr [2];
    logic [ADDR_WIDTH-1:0] st_addr [2];
    logic [DATA_WIDTH-1:0] st_data [2];

    logic [1:0] ld_elig;
    logic       ld_both;
    logic       ld_any;
    logic       ld_sel;
    logic       st_both;
    logic       st_any;
    logic       st_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign ld_addr[gi] = ldreq_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign st_addr[gi] = streq_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign st_data[gi] = streq_data[gi*DATA_WIDTH +: DATA_WIDTH];

            // A requester may only issue when its response slot is free or being drained this cycle.
            assign ld_elig[gi] = ldreq_valid[gi] & ~inflight_reg[gi]
                               & (~resp_valid_reg[gi] | ldresp_ready[gi]);

            assign ldreq_ready[gi] = ld_any & (ld_sel == 1'(gi));
            assign streq_ready[gi] = st_any & (st_sel == 1'(gi));
            assign ldresp_data[gi*DATA_WIDTH +: DATA_WIDTH] = resp_data_reg[gi];
        end
    endgenerate

    assign ld_both = &ld_elig;
    assign ld_any  = rst & (|ld_elig);
    assign ld_sel  = ld_both ? ld_ptr_reg : ld_elig[1];

    assign st_both = &streq_valid;
    assign st_any  = rst & (|streq_valid);
    assign st_sel  = st_both ? st_ptr_reg : streq_valid[1];

    assign ce0      = ld_any;
    assign we0      = 1'b0;
    assign address0 = ld_any ? ld_addr[ld_sel] : '0;

    assign ce1      = st_any;
    assign we1      = st_any;
    assign address1 = st_any ? st_addr[st_sel] : '0;
    assign dout1    = st_any ? st_data[st_sel] : '0;

    assign ldresp_valid = resp_valid_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_ptr_reg <= 1'b0;
            st_ptr_reg <= 1'b0;
        end else begin
            if (ld_any && ld_both) begin
                ld_ptr_reg <= ~ld_sel;
            end
            if (st_any && st_both) begin
                st_ptr_reg <= ~st_sel;
            end
        end
    end

    // din0 belongs to whichever requester was granted on the previous cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_reg   <= 2'b00;
            resp_valid_reg <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                resp_data_reg[i] <= '0;
            end
        end else begin
            inflight_reg <= ldreq_ready;
            for (int i = 0; i < 2; i++) begin
                if (inflight_reg[i]) begin
                    resp_valid_reg[i] <= 1'b1;
                    resp_data_reg[i]  <= din0;
                end else if (resp_valid_reg[i] && ldresp_ready[i]) begin
                    resp_valid_reg[i] <= 1'b0;
                end
            end
        end
    end

`ifdef BRAM_ARB_STATS_EN
    logic [15:0] ld_conf_reg;
    logic [15:0] st_conf_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_conf_reg <= '0;
            st_conf_reg <= '0;
        end else begin
            if (ld_both && ld_conf_reg != 16'hFFFF) begin
                ld_conf_reg <= ld_conf_reg + 16'd1;
            end
            if (st_both && st_conf_reg != 16'hFFFF) begin
                st_conf_reg <= st_conf_reg + 16'd1;
            end
        end
    end

    assign stat_ld_conflicts = ld_conf_reg;
    assign stat_st_conflicts = st_conf_reg;
`endif

endmodule

// File: tb/tb_bram_dual_requester_arbiter.sv
// Testbench for bram_dual_requester_arbiter: BRAM environment model, transaction-level reference, directed and random scenarios.
// Statistics outputs are checked only when BRAM_ARB_STATS_EN is defined.
module tb_bram_dual_requester_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    ldreq_valid = '0;
    logic [1:0]    ldreq_ready;
    logic [2*AW-1:0] ldreq_addr = '0;
    logic [1:0]    ldresp_valid;
    logic [1:0]    ldresp_ready = '0;
    logic [2*DW-1:0] ldresp_data;
    logic [1:0]    streq_valid = '0;
    logic [1:0]    streq_ready;
    logic [2*AW-1:0] streq_addr = '0;
    logic [2*DW-1:0] streq_data = '0;
    logic          ce0, we0, ce1, we1;
    logic [AW-1:0] address0, address1;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout1;
`ifdef BRAM_ARB_STATS_EN
    logic [15:0]   stat_ld_conflicts, stat_st_conflicts;
`endif

    int total = 0;
    int bad = 0;
    int n_ld_resp = 0;
    int n_st = 0;

    always #5 clk = ~clk;

    bram_dual_requester_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .ldreq_valid(ldreq_valid), .ldreq_ready(ldreq_ready), .ldreq_addr(ldreq_addr),
        .ldresp_valid(ldresp_valid), .ldresp_ready(ldresp_ready), .ldresp_data(ldresp_data),
        .streq_valid(streq_valid), .streq_ready(streq_ready),
        .streq_addr(streq_addr), .streq_data(streq_data),
        .ce0(ce0), .we0(we0), .address0(address0), .din0(din0),
        .ce1(ce1), .we1(we1), .address1(address1), .dout1(dout1)
`ifdef BRAM_ARB_STATS_EN
        , .stat_ld_conflicts(stat_ld_conflicts), .stat_st_conflicts(stat_st_conflicts)
`endif
    );

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hA5C300, a};
    endfunction

    // Read-first BRAM: unwritten words hold init_word(addr).
    logic [31:0] mem [256];
    bit          mem_w [256];
    always @(posedge clk) begin
        if (ce0) din0 <= mem_w[address0[7:0]] ? mem[address0[7:0]] : init_word(address0[7:0]);
        if (ce1 && we1) begin
            mem[address1[7:0]]   <= dout1;
            mem_w[address1[7:0]] <= 1'b1;
        end
    end

    // Reference: per-requester pending load / response slot, golden memory, two fairness pointers.
    bit          m_ldp, m_stp;
    bit [1:0]    m_inf, m_rv;
    logic [31:0] m_infd [2];
    logic [31:0] m_rd [2];
    logic [31:0] gold [256];
    bit          gold_w [256];
    int          m_ldc, m_stc;

    always @(negedge clk) begin : model
        logic [1:0]  el, exp_lr, exp_sr;
        logic        g, s, lgv, sgv;
        logic [31:0] ea0, ea1, ed1;
        logic [7:0]  la;
        if (!rst) begin
            total++;
            if (ldreq_ready !== 2'b00 || streq_ready !== 2'b00 || ldresp_valid !== 2'b00 ||
                ce0 !== 1'b0 || ce1 !== 1'b0 || we1 !== 1'b0 || address0 !== '0 ||
                address1 !== '0 || dout1 !== '0 || ldresp_data !== '0) begin
                bad++;
                $display("FAIL model_reset: got ldr=%b str=%b rv=%b ce0=%b ce1=%b we1=%b a0=%h a1=%h required all zero",
                         ldreq_ready, streq_ready, ldresp_valid, ce0, ce1, we1, address0, address1);
            end
            m_ldp = 0; m_stp = 0; m_inf = 0; m_rv = 0; m_ldc = 0; m_stc = 0;
        end else begin
            for (int i = 0; i < 2; i++)
                el[i] = ldreq_valid[i] && !m_inf[i] && (!m_rv[i] || ldresp_ready[i]);
            lgv = |el;
            g = (&el) ? m_ldp : el[1];
            exp_lr = lgv ? (g ? 2'b10 : 2'b01) : 2'b00;
            ea0 = lgv ? ldreq_addr[int'(g)*32 +: 32] : 32'h0;
            sgv = |streq_valid;
            s = (&streq_valid) ? m_stp : streq_valid[1];
            exp_sr = sgv ? (s ? 2'b10 : 2'b01) : 2'b00;
            ea1 = sgv ? streq_addr[int'(s)*32 +: 32] : 32'h0;
            ed1 = sgv ? streq_data[int'(s)*32 +: 32] : 32'h0;

            total++;
            if (ldreq_ready !== exp_lr || ce0 !== lgv || address0 !== ea0 || we0 !== 1'b0) begin
                bad++;
                $display("FAIL model_load_port: got ready=%b ce0=%b we0=%b a0=%h required ready=%b ce0=%b we0=0 a0=%h",
                         ldreq_ready, ce0, we0, address0, exp_lr, lgv, ea0);
            end
            total++;
            if (streq_ready !== exp_sr || ce1 !== sgv || we1 !== sgv || address1 !== ea1 || dout1 !== ed1) begin
                bad++;
                $display("FAIL model_store_port: got ready=%b ce1=%b we1=%b a1=%h d1=%h required ready=%b ce1=we1=%b a1=%h d1=%h",
                         streq_ready, ce1, we1, address1, dout1, exp_sr, sgv, ea1, ed1);
            end
            total++;
            if (ldresp_valid !== m_rv) begin
                bad++;
                $display("FAIL model_resp_valid: got %b required %b", ldresp_valid, m_rv);
            end
            for (int i = 0; i < 2; i++) begin
                if (m_rv[i]) begin
                    total++;
                    if (ldresp_data[i*32 +: 32] !== m_rd[i]) begin
                        bad++;
                        $display("FAIL model_resp_data%0d: got %h required %h", i, ldresp_data[i*32 +: 32], m_rd[i]);
                    end
                end
            end
`ifdef BRAM_ARB_STATS_EN
            total++;
            if (stat_ld_conflicts !== 16'(m_ldc) || stat_st_conflicts !== 16'(m_stc)) begin
                bad++;
                $display("FAIL model_stats: got ld=%0d st=%0d required ld=%0d st=%0d",
                         stat_ld_conflicts, stat_st_conflicts, m_ldc, m_stc);
            end
            if (&el && m_ldc < 65535) m_ldc++;
            if (&streq_valid && m_stc < 65535) m_stc++;
`endif
            for (int i = 0; i < 2; i++) begin
                if (m_rv[i] && ldresp_ready[i]) begin
                    n_ld_resp++;
                    $display("load  req%0d data=%h", i, m_rd[i]);
                end
                if (m_inf[i]) begin
                    m_rv[i] = 1'b1;
                    m_rd[i] = m_infd[i];
                end else if (m_rv[i] && ldresp_ready[i]) begin
                    m_rv[i] = 1'b0;
                end
            end
            m_inf = 2'b00;
            if (lgv) begin
                la = ea0[7:0];
                m_inf[g] = 1'b1;
                m_infd[g] = gold_w[la] ? gold[la] : init_word(la);
            end
            if (&el) m_ldp = !g;
            if (sgv) begin
                gold[ea1[7:0]] = ed1;
                gold_w[ea1[7:0]] = 1'b1;
                n_st++;
                $display("store req%0d addr=%h data=%h", int'(s), ea1, ed1);
            end
            if (&streq_valid) m_stp = !s;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ldreq_valid = 2'b11; streq_valid = 2'b11; ldresp_ready = 2'b11;
        ldreq_addr = {32'h8, 32'h4};
        streq_addr = {32'hF4, 32'hF0}; streq_data = {32'h2, 32'h1};
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({ldreq_ready, streq_ready, ce0, ce1, ldresp_valid} !== 8'h00) begin
                bad++;
                $display("FAIL test_reset_held: got ldr=%b str=%b ce0=%b ce1=%b rv=%b required 0",
                         ldreq_ready, streq_ready, ce0, ce1, ldresp_valid);
            end
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (ldreq_ready !== 2'b01) begin
            bad++;
            $display("FAIL test_reset_first_grant: got %b required 01", ldreq_ready);
        end
        tick();
        ldreq_valid = 2'b00; streq_valid = 2'b00;
        repeat (4) tick();
    endtask

    task automatic test_single_load();
        ldreq_addr = {32'h0, 32'h10}; ldreq_valid = 2'b01; ldresp_ready = 2'b11;
        @(negedge clk);
        total++;
        if (ce0 !== 1'b1 || address0 !== 32'h10 || ldreq_ready !== 2'b01) begin
            bad++;
            $display("FAIL test_single_issue: got ce0=%b a0=%h ready=%b required 1 00000010 01", ce0, address0, ldreq_ready);
        end
        tick();
        ldreq_valid = 2'b00;
        @(negedge clk);
        total++;
        if (ldresp_valid !== 2'b00) begin
            bad++;
            $display("FAIL test_single_t1: got rv=%b required 00", ldresp_valid);
        end
        @(negedge clk);
        total++;
        if (ldresp_valid !== 2'b01 || ldresp_data[31:0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL test_single_t2: got rv=%b data=%h required 01 deadbeef", ldresp_valid, ldresp_data[31:0]);
        end
        @(negedge clk);
        total++;
        if (ldresp_valid !== 2'b00) begin
            bad++;
            $display("FAIL test_single_drain: got rv=%b required 00", ldresp_valid);
        end
        tick();
    endtask

    task automatic test_load_contention();
        logic [1:0] prev;
        prev = 2'b00;
        ldreq_addr = {32'h8, 32'h4}; ldreq_valid = 2'b11; ldresp_ready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (ce0 !== 1'b1 || (k > 0 && ldreq_ready !== ~prev)) begin
                bad++;
                $display("FAIL test_contention_grant%0d: got ce0=%b ready=%b required ce0=1 ready=%b", k, ce0, ldreq_ready, ~prev);
            end
            prev = ldreq_ready;
            if (ldresp_valid[0]) begin
                total++;
                if (ldresp_data[31:0] !== init_word(8'h4)) begin
                    bad++;
                    $display("FAIL test_contention_data0: got %h required %h", ldresp_data[31:0], init_word(8'h4));
                end
            end
            if (ldresp_valid[1]) begin
                total++;
                if (ldresp_data[63:32] !== init_word(8'h8)) begin
                    bad++;
                    $display("FAIL test_contention_data1: got %h required %h", ldresp_data[63:32], init_word(8'h8));
                end
            end
            tick();
        end
        ldreq_valid = 2'b00;
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        ldreq_addr = {32'h8, 32'h4}; ldresp_ready = 2'b01; ldreq_valid = 2'b10;
        @(negedge clk);
        tick();
        ldreq_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ldresp_valid[1] !== 1'b1) begin
            bad++;
            $display("FAIL test_bp_slot_full: got rv1=%b required 1", ldresp_valid[1]);
        end
        tick();
        ldreq_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (ldreq_ready[1] !== 1'b0 || ldreq_ready[0] !== (k % 2 == 0)) begin
                bad++;
                $display("FAIL test_bp_cycle%0d: got ready=%b required %b", k, ldreq_ready, {1'b0, k % 2 == 0});
            end
            tick();
        end
        ldresp_ready = 2'b11;
        @(negedge clk);
        total++;
        if (ldreq_ready !== 2'b10 || ldresp_valid[1] !== 1'b1 || ldresp_data[63:32] !== init_word(8'h8)) begin
            bad++;
            $display("FAIL test_bp_regrant: got ready=%b rv1=%b data=%h required 10 1 %h",
                     ldreq_ready, ldresp_valid[1], ldresp_data[63:32], init_word(8'h8));
        end
        tick();
        ldreq_valid = 2'b00;
        repeat (4) tick();
    endtask

    task automatic test_store_contention();
        logic [1:0] prev;
        prev = 2'b00;
        streq_addr = {32'h24, 32'h20}; streq_data = {32'd2, 32'd1}; streq_valid = 2'b11;
        ldreq_addr = {32'h0, 32'h20}; ldreq_valid = 2'b01; ldresp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (ce1 !== 1'b1 || we1 !== 1'b1 || (streq_ready !== 2'b01 && streq_ready !== 2'b10) ||
                (k > 0 && streq_ready !== ~prev) ||
                (streq_ready == 2'b01 && (address1 !== 32'h20 || dout1 !== 32'd1)) ||
                (streq_ready == 2'b10 && (address1 !== 32'h24 || dout1 !== 32'd2))) begin
                bad++;
                $display("FAIL test_store_cycle%0d: got ce1=%b we1=%b ready=%b a1=%h d1=%h required alternating owner after %b",
                         k, ce1, we1, streq_ready, address1, dout1, prev);
            end
            prev = streq_ready;
            if (k == 0) begin
                total++;
                if (ldreq_ready !== 2'b01) begin
                    bad++;
                    $display("FAIL test_store_load_issue: got %b required 01", ldreq_ready);
                end
            end
            if (k == 2) begin
                total++;
                if (ldresp_valid[0] !== 1'b1 || ldresp_data[31:0] !== init_word(8'h20)) begin
                    bad++;
                    $display("FAIL test_store_read_first: got rv0=%b data=%h required 1 %h",
                             ldresp_valid[0], ldresp_data[31:0], init_word(8'h20));
                end
            end
            tick();
            ldreq_valid = 2'b00;
        end
        streq_valid = 2'b00;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_load();
        ldreq_addr = {32'h0, 32'h30}; ldreq_valid = 2'b01; ldresp_ready = 2'b11;
        @(negedge clk);
        total++;
        if (ldreq_ready !== 2'b01) begin
            bad++;
            $display("FAIL test_midreset_issue: got %b required 01", ldreq_ready);
        end
        tick();
        rst = 1'b0; ldreq_valid = 2'b00;
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (ldresp_valid !== 2'b00) begin
                bad++;
                $display("FAIL test_midreset_discard%0d: got rv=%b required 00", k, ldresp_valid);
            end
        end
        tick();
        ldreq_valid = 2'b01;
        @(negedge clk);
        tick();
        ldreq_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ldresp_valid !== 2'b01 || ldresp_data[31:0] !== init_word(8'h30)) begin
            bad++;
            $display("FAIL test_midreset_next: got rv=%b data=%h required 01 %h", ldresp_valid, ldresp_data[31:0], init_word(8'h30));
        end
        repeat (2) tick();
    endtask

    task automatic test_random();
        int ld0, st0;
        ld0 = n_ld_resp;
        st0 = n_st;
        for (int k = 0; k < 400; k++) begin
            tick();
            rst          = ($urandom_range(99) != 0);
            ldreq_valid  = 2'($urandom_range(3));
            ldresp_ready = 2'($urandom_range(3));
            streq_valid  = 2'($urandom_range(3));
            ldreq_addr   = {32'($urandom_range(63)), 32'($urandom_range(63))};
            streq_addr   = {32'($urandom_range(63)), 32'($urandom_range(63))};
            streq_data   = {32'($urandom), 32'($urandom)};
        end
        tick();
        rst = 1'b1; ldreq_valid = 2'b00; streq_valid = 2'b00; ldresp_ready = 2'b11;
        repeat (4) tick();
        total++;
        if (n_ld_resp - ld0 < 20 || n_st - st0 < 20) begin
            bad++;
            $display("FAIL test_random_activity: got loads=%0d stores=%0d required at least 20 each", n_ld_resp - ld0, n_st - st0);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_load_contention();
        test_backpressure();
        test_store_contention();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
